// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI constants, AR state encoding and helpers for the instruction-fetch AXI read bridge.
package inst_axi_rd_bridge_pkg;

  localparam int AXI_ID_W = 4;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

  typedef enum logic {
    AR_IDLE,
    AR_BUSY
  } ar_state_e;

  // SRAM-style size is log2(bytes); AXI arsize uses the same encoding, one bit wider.
  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/inst_axi_rd_bridge_axi_r_slice.sv
// One-entry registered buffer for the AXI R channel (valid + 32-bit data).
// Only instantiated when INST_AXI_RD_RSP_REG_EN is defined.
module axi_r_slice (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    in_ready = !valid_q || out_ready;
    if (valid_q && out_ready) valid_d = 1'b0;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// SRAM-like instruction port to single-beat AXI read master, in-order responses.
// Optional registered R buffer enabled by defining INST_AXI_RD_RSP_REG_EN.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [AXI_ID_W-1:0]   AR_ID           = 4'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_sram_req,
  input  logic [1:0]          inst_sram_size,
  input  logic [31:0]         inst_sram_addr,
  output logic                inst_sram_addr_ok,
  output logic                inst_sram_data_ok,
  output logic [31:0]         inst_sram_rdata,
  output logic [AXI_ID_W-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                arvalid,
  input  logic                arready,
  input  logic [AXI_ID_W-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ar_state_e         state_q, state_d;
  logic [31:0]       araddr_q, araddr_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              addr_hs;
  logic              rsp_done;
  logic              unused_inputs;

  // Responses are in order and single-beat, so ID, resp and last carry no information here.
  assign unused_inputs = ^{rid, rresp, rlast};

  assign arid    = AR_ID;
  assign arlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state_q == AR_BUSY);
  assign araddr  = araddr_q;
  assign arsize  = arsize_q;

  // addr_ok must not look at req so the fetch stage can build req from its own allow_in.
  assign inst_sram_addr_ok = !reset && (state_q == AR_IDLE) && (cnt_q < CNT_MAX);
  assign addr_hs           = inst_sram_req && inst_sram_addr_ok;

`ifdef INST_AXI_RD_RSP_REG_EN
  logic slice_in_ready;

  axi_r_slice u_r_slice (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rvalid && rready),
    .in_ready  (slice_in_ready),
    .in_data   (rdata),
    .out_valid (inst_sram_data_ok),
    .out_ready (1'b1),
    .out_data  (inst_sram_rdata)
  );

  assign rready   = (cnt_q != '0) && slice_in_ready;
  assign rsp_done = inst_sram_data_ok;
`else
  assign rready            = (cnt_q != '0);
  assign inst_sram_data_ok = rvalid && rready;
  assign inst_sram_rdata   = rdata;
  assign rsp_done          = inst_sram_data_ok;
`endif

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    unique case (state_q)
      AR_IDLE: begin
        if (addr_hs) begin
          state_d  = AR_BUSY;
          araddr_d = inst_sram_addr;
          arsize_d = axi_size(inst_sram_size);
        end
      end
      AR_BUSY: begin
        if (arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({addr_hs, rsp_done})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // The slave shares this reset, so dropping arvalid mid-handshake is safe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= AR_IDLE;
      araddr_q <= 32'h0;
      arsize_q <= AXI_SIZE_WORD;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge (default build, MAX_OUTSTANDING=2).
module tb_inst_axi_rd_bridge;
  import inst_axi_rd_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(2), .AR_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  // Inputs change just after a rising edge; outputs are sampled at the falling edge.
  task automatic applyStimulus(input logic rst, input logic req, input logic [31:0] addr,
                               input logic ar_rdy, input logic r_vld, input logic [31:0] r_dat);
    @(posedge clk);
    #1;
    reset          = rst;
    inst_sram_req  = req;
    inst_sram_addr = addr;
    arready        = ar_rdy;
    rvalid         = r_vld;
    rdata          = r_dat;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; inst_sram_req = 1'b0; inst_sram_size = 2'b10; inst_sram_addr = 32'h0;
    arready = 1'b0; rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;

    // Reset values
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("rst_rready", 32'(rready), 32'd0);
    checkOutput("rst_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    checkOutput("rst_data_ok", 32'(inst_sram_data_ok), 32'd0);
    checkOutput("rst_araddr", araddr, 32'h0);
    checkOutput("rst_arsize", 32'(arsize), 32'h2);

    // Minimum-latency fetch
    applyStimulus(1'b0, 1'b1, 32'h1C00_0000, 1'b1, 1'b0, 32'h0);
    checkOutput("c0_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    checkOutput("c0_arvalid", 32'(arvalid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c1_arvalid", 32'(arvalid), 32'd1);
    checkOutput("c1_araddr", araddr, 32'h1C00_0000);
    checkOutput("c1_arsize", 32'(arsize), 32'h2);
    checkOutput("c1_arlen", 32'(arlen), 32'h0);
    checkOutput("c1_arburst", 32'(arburst), 32'h1);
    checkOutput("c1_arid", 32'(arid), 32'h0);
    checkOutput("c1_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    checkOutput("c1_rready", 32'(rready), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0280_0C0C);
    checkOutput("c2_data_ok", 32'(inst_sram_data_ok), 32'd1);
    checkOutput("c2_rdata", inst_sram_rdata, 32'h0280_0C0C);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("c3_rready", 32'(rready), 32'd0);
    checkOutput("c3_data_ok", 32'(inst_sram_data_ok), 32'd0);

    // arready stalled for three cycles
    applyStimulus(1'b0, 1'b1, 32'h1C00_0004, 1'b0, 1'b0, 32'h0);
    checkOutput("stall_accept", 32'(inst_sram_addr_ok), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h1C00_0008, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("stall%0d_arvalid", i), 32'(arvalid), 32'd1);
      checkOutput($sformatf("stall%0d_araddr", i), araddr, 32'h1C00_0004);
      checkOutput($sformatf("stall%0d_addr_ok", i), 32'(inst_sram_addr_ok), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 32'h1C00_0008, 1'b1, 1'b0, 32'h0);
    checkOutput("stall3_arvalid", 32'(arvalid), 32'd1);
    checkOutput("stall3_araddr", araddr, 32'h1C00_0004);
    checkOutput("stall3_addr_ok", 32'(inst_sram_addr_ok), 32'd0);

    // Second outstanding read fills the limit
    applyStimulus(1'b0, 1'b1, 32'h1C00_0010, 1'b1, 1'b0, 32'h0);
    checkOutput("lim_accept2", 32'(inst_sram_addr_ok), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h1C00_0014, 1'b1, 1'b0, 32'h0);
    checkOutput("lim_arvalid", 32'(arvalid), 32'd1);
    checkOutput("lim_araddr", araddr, 32'h1C00_0010);
    applyStimulus(1'b0, 1'b1, 32'h1C00_0014, 1'b1, 1'b0, 32'h0);
    checkOutput("lim_third_blocked", 32'(inst_sram_addr_ok), 32'd0);
    checkOutput("lim_arvalid_low", 32'(arvalid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA_0001);
    checkOutput("lim_ret_data_ok", 32'(inst_sram_data_ok), 32'd1);
    checkOutput("lim_ret_rdata", inst_sram_rdata, 32'hAAAA_0001);
    checkOutput("lim_ret_addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("lim_reopen", 32'(inst_sram_addr_ok), 32'd1);
    checkOutput("lim_cnt1_rready", 32'(rready), 32'd1);

    // Address and response handshakes in the same cycle with one in flight
    applyStimulus(1'b0, 1'b1, 32'h1C00_0020, 1'b1, 1'b1, 32'hAAAA_0002);
    checkOutput("same_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    checkOutput("same_data_ok", 32'(inst_sram_data_ok), 32'd1);
    checkOutput("same_rdata", inst_sram_rdata, 32'hAAAA_0002);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("same_arvalid", 32'(arvalid), 32'd1);
    checkOutput("same_araddr", araddr, 32'h1C00_0020);
    checkOutput("same_rready", 32'(rready), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hAAAA_0003);
    checkOutput("same_last_data_ok", 32'(inst_sram_data_ok), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("same_drained_rready", 32'(rready), 32'd0);

    // Spurious rvalid with nothing outstanding
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    checkOutput("spur_rready", 32'(rready), 32'd0);
    checkOutput("spur_data_ok", 32'(inst_sram_data_ok), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("spur_cnt0_rready", 32'(rready), 32'd0);
    checkOutput("spur_addr_ok", 32'(inst_sram_addr_ok), 32'd1);

    // Reset while arvalid=1 and two reads outstanding
    applyStimulus(1'b0, 1'b1, 32'h1C00_0030, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h1C00_0034, 1'b0, 1'b0, 32'h0);
    checkOutput("mid_accept2", 32'(inst_sram_addr_ok), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkOutput("mid_pre_arvalid", 32'(arvalid), 32'd1);
    checkOutput("mid_pre_rready", 32'(rready), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h1C00_0040, 1'b1, 1'b0, 32'h0);
    checkOutput("mid_post_arvalid", 32'(arvalid), 32'd0);
    checkOutput("mid_post_rready", 32'(rready), 32'd0);
    checkOutput("mid_post_addr_ok", 32'(inst_sram_addr_ok), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("fresh_arvalid", 32'(arvalid), 32'd1);
    checkOutput("fresh_araddr", araddr, 32'h1C00_0040);
    checkOutput("fresh_rready", 32'(rready), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
    checkOutput("fresh_data_ok", 32'(inst_sram_data_ok), 32'd1);
    checkOutput("fresh_rdata", inst_sram_rdata, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    checkOutput("fresh_cnt0_rready", 32'(rready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_axi_rd_bridge.md
Name: inst_axi_rd_bridge

Overview:
- Sits directly upstream of the fetch stage (stage1_IF).
- Converts the fetch stage's SRAM-like instruction port (req / addr_ok / data_ok) into an AXI3/AXI4 read-only master with single-beat bursts.
- Tracks in-flight reads with a counter and returns instruction words in request order.
- The fetch stage owns cancel handling; this block returns every accepted request exactly once.

Parameters:
- MAX_OUTSTANDING, 2, maximum accepted-but-unreturned reads (1..7).
- AR_ID, 4'd0, constant arid driven on every request.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_sram_req  in  1  fetch request valid
- inst_sram_size  in  2  log2 bytes (2'b10 = word)
- inst_sram_addr  in  32  fetch byte address
- inst_sram_addr_ok  out  1  request accepted this cycle (when req=1)
- inst_sram_data_ok  out  1  instruction word valid this cycle
- inst_sram_rdata  out  32  instruction word
- arid  out  4  read ID (AR_ID)
- araddr  out  32  read address
- arlen  out  8  constant 0
- arsize  out  3  {1'b0, latched size}
- arburst  out  2  constant 2'b01 (INCR)
- arlock  out  2  constant 0
- arcache  out  4  constant 0
- arprot  out  3  constant 0
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  4  read ID (ignored; responses in order)
- rdata  in  32  read data
- rresp  in  2  read response (ignored)
- rlast  in  1  last beat (always 1 for arlen=0)
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- AR FSM, states AR_IDLE and AR_BUSY.
  - Reset state is AR_IDLE.
  - AR_IDLE -> AR_BUSY on req && addr_ok; inst_sram_addr and size are latched into araddr/arsize that cycle.
  - AR_BUSY -> AR_IDLE on arvalid && arready.
- arvalid = (state == AR_BUSY). Registered, so it rises the cycle after the addr handshake. araddr/arsize stay stable while arvalid && !arready.
- inst_sram_addr_ok = (state == AR_IDLE) && (cnt < MAX_OUTSTANDING).
  - No combinational dependence on req, so the fetch stage may derive req from its own allow_in without a loop.
- Outstanding counter cnt, width $clog2(MAX_OUTSTANDING+1), reset 0.
  - +1 on addr handshake.
  - -1 on R handshake.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows.
- rready = (cnt != 0). An rvalid while cnt==0 is not accepted (protocol-error guard).
- inst_sram_data_ok = rvalid && rready.
- inst_sram_rdata = rdata, combinational pass-through. Same-cycle data is required because the fetch stage buffers the word only when data_ok is high.
- Minimum latency: addr_ok at cycle N, arvalid at N+1, earliest data_ok at N+2 (arready and rvalid both immediate).
- Reset values: arvalid=0, rready=0, addr_ok=0, data_ok=0, araddr=0, arsize=3'b010, cnt=0.
- Reset mid-transaction:
  - All state clears immediately, including dropping arvalid.
  - Legal only because the AXI slave shares this reset domain.
  - No pending response survives reset.
- Back-to-back operation: a new request can be accepted the cycle after AR_BUSY -> AR_IDLE, subject to cnt.

Optional Feature:
- Macro INST_AXI_RD_RSP_REG_EN.
- Defined:
  - R channel passes through a one-entry registered buffer (valid + 32-bit data).
  - rready = (cnt != 0) && (buffer empty || buffer draining this cycle).
  - data_ok and rdata come from the buffer register, adding one cycle of latency (earliest data_ok at N+3).
  - cnt decrements when the word leaves the buffer, not on the R handshake.
  - The buffer clears on reset.
- Undefined: combinational pass-through as described above.

Decomposition:
- Shared header (width.vh): AXI constants AXI_BURST_INCR=2'b01, AXI_SIZE_WORD=3'b010, and an AXI ID width define of 4.
- One natural sub-module, axi_r_slice: the one-entry response register, instantiated only under INST_AXI_RD_RSP_REG_EN.

Test Plan:
- Reset, then req=1, addr=0x1C000000, arready=1, rvalid returned one cycle after AR handshake with rdata=0x02800C0C -> addr_ok at cycle 0; arvalid at cycle 1 with araddr=0x1C000000, arsize=3'b010, arlen=0; data_ok=1 with rdata=0x02800C0C at cycle 2.
- arready held low for 3 cycles -> arvalid stays high and araddr stays stable for 4 cycles; addr_ok stays 0 throughout.
- MAX_OUTSTANDING=2, two requests accepted, no R response -> third req sees addr_ok=0; one R handshake returns -> addr_ok returns to 1 the next cycle.
- Addr handshake and R handshake in the same cycle with cnt=1 -> cnt stays 1; data_ok=1.
- rvalid=1 injected while cnt=0 -> rready=0, data_ok=0, cnt stays 0.
- reset asserted with arvalid=1 and cnt=2 -> next cycle arvalid=0, cnt=0, rready=0; a fresh request is accepted normally afterwards.
